// File: rtl/fifo_read_port.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_port
// Description : Read-side controller for a synchronous FIFO. Pops words from
//               the FIFO read port and presents them on a valid/ready output
//               stream. A 2-entry skid buffer hides the FIFO's one-cycle read
//               latency, so a word can be delivered every cycle.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               fifo_empty    - FIFO empty flag (same-cycle)
//               fifo_rd_en    - read strobe to FIFO, one pop per high cycle
//               fifo_dout     - FIFO read data, valid the cycle after a read
//               m_valid       - output word available
//               m_data        - output word (head of skid buffer)
//               m_ready       - consumer accepts when m_valid && m_ready
//               rd_count      - words accepted since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_port #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  rd_count
);

    localparam logic [1:0] c_OCC_FULL = 2'd2;

    logic [DATA_W-1:0] r_buf0;   // head entry, drives m_data
    logic [DATA_W-1:0] r_buf1;   // second entry
    logic [1:0]        r_occ;    // buffer occupancy, 0..2
    logic              r_infl;   // read issued last cycle; data on fifo_dout now
    logic [CNT_W-1:0]  r_count;

    logic              w_pop;
    logic              w_capture;
    logic [1:0]        w_fill;

    assign w_pop     = m_valid && m_ready;
    assign w_capture = r_infl;

    // Occupancy plus in-flight word never exceeds 2, so 2 bits suffice.
    assign w_fill    = r_occ + {1'b0, r_infl};

    // Only issue a read when the word it returns is guaranteed a slot: either
    // the buffer has room counting the word already in flight, or a pop this
    // cycle frees one.
    assign fifo_rd_en = !rst && !fifo_empty && ((w_fill < c_OCC_FULL) || w_pop);

    assign m_valid  = (r_occ != 2'd0);
    assign m_data   = r_buf0;
    assign rd_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf0  <= '0;
            r_buf1  <= '0;
            r_occ   <= 2'd0;
            r_infl  <= 1'b0;
            r_count <= '0;
        end else begin
            r_infl <= fifo_rd_en;

            case ({w_capture, w_pop})
                2'b10: begin
                    // Capture into the first free slot.
                    if (r_occ == 2'd0) begin
                        r_buf0 <= fifo_dout;
                    end else begin
                        r_buf1 <= fifo_dout;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Head leaves while a new word arrives; occupancy holds.
                    if (r_occ == 2'd1) begin
                        r_buf0 <= fifo_dout;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= fifo_dout;
                    end
                end
                default: begin
                end
            endcase

            if (w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_read_port
// Description : Directed bench for fifo_read_port. A behavioural FIFO feeds
//               two instances (16-bit and 4-bit delivered-word counters) with
//               identical stimulus; a scoreboard tracks expected word order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_port;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic [15:0] rd_count;

    logic       fifo_rd_en4;
    logic       m_valid4;
    logic [7:0] m_data4;
    logic [3:0] rd_count4;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural FIFO storage: written only by the stimulus process,
    // read pointer advanced only by the model process.
    logic [7:0] mem [0:2047];
    int         pushed = 0;
    int         popped = 0;
    logic       gap    = 1'b0;
    logic       flush  = 1'b0;
    logic [7:0] next_val;
    logic [7:0] sb [$];

    assign fifo_empty = gap || (pushed == popped);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (flush) begin
            popped    <= pushed;
            fifo_dout <= 8'($urandom);
        end else if (fifo_rd_en) begin
            fifo_dout <= mem[popped[10:0]];
            popped    <= popped + 1;
        end else begin
            // Garbage on idle cycles: the design must ignore it.
            fifo_dout <= 8'($urandom);
        end
    end

    fifo_read_port #(.DATA_W(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .rd_count   (rd_count)
    );

    fifo_read_port #(.DATA_W(8), .CNT_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en4),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid4),
        .m_data     (m_data4),
        .m_ready    (m_ready),
        .rd_count   (rd_count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushq(input logic [7:0] v);
        mem[pushed[10:0]] = v;
        sb.push_back(v);
        pushed = pushed + 1;
    endtask

    // One cycle: drive inputs just after the falling edge, then sample.
    task automatic step(input logic rdy, input logic rs, input int np, input logic gp);
        @(negedge clk);
        m_ready = rdy;
        rst     = rs;
        gap     = gp;
        for (int k = 0; k < np; k++) begin
            pushq(next_val);
            next_val = next_val + 8'd1;
        end
        #1;
        chk("rd_while_empty",  {31'b0, fifo_rd_en  && fifo_empty}, 32'd0);
        chk("rd4_while_empty", {31'b0, fifo_rd_en4 && fifo_empty}, 32'd0);
        chk("occ_le2", {31'b0, dut.r_occ <= 2'd2}, 32'd1);
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                if (m_valid4) chk("data4", {24'b0, m_data4}, {24'b0, sb[0]});
                chk("data_order", {24'b0, m_data}, {24'b0, sb.pop_front()});
            end
        end
    endtask

    initial begin
        int rdn;
        int sent;
        int np;
        rst      = 1'b1;
        m_ready  = 1'b0;
        next_val = 8'h01;
        for (int i = 0; i < 16; i++) begin
            pushq(next_val);
            next_val = next_val + 8'd1;
        end

        // Reset held 3 cycles with a non-empty FIFO.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 0, 1'b0);
            chk("rst_rd_en",    {31'b0, fifo_rd_en}, 32'd0);
            chk("rst_m_valid",  {31'b0, m_valid},    32'd0);
            chk("rst_m_data",   {24'b0, m_data},     32'd0);
            chk("rst_rd_count", {16'b0, rd_count},   32'd0);
        end

        // Streaming 0x01..0x10 with m_ready high.
        step(1'b1, 1'b0, 0, 1'b0);
        chk("first_rd_en", {31'b0, fifo_rd_en}, 32'd1);
        chk("lat_valid0",  {31'b0, m_valid},    32'd0);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("lat_valid1",  {31'b0, m_valid},    32'd0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 0, 1'b0);
            chk("stream_valid", {31'b0, m_valid}, 32'd1);
            chk("stream_data",  {24'b0, m_data},  32'(i + 1));
        end
        step(1'b1, 1'b0, 0, 1'b0);
        chk("stream_done_valid", {31'b0, m_valid},  32'd0);
        chk("stream_count",      {16'b0, rd_count}, 32'd16);
        chk("count4_at16",       {28'b0, rd_count4}, 32'd0);

        // Back-pressure with 0xA0..0xA5.
        next_val = 8'hA0;
        step(1'b0, 1'b0, 6, 1'b0);
        rdn = int'(fifo_rd_en);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b0, 0, 1'b0);
            rdn += int'(fifo_rd_en);
            if (i >= 2) begin
                chk("bp_hold_valid", {31'b0, m_valid}, 32'd1);
                chk("bp_hold_data",  {24'b0, m_data},  32'h0A0);
            end
        end
        chk("bp_read_count", 32'(rdn), 32'd2);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 0, 1'b0);
            chk("bp_rel_valid", {31'b0, m_valid}, 32'd1);
            chk("bp_rel_data",  {24'b0, m_data},  32'(8'hA0 + i));
            if (i == 1) begin
                chk("count_17",  {16'b0, rd_count},  32'd17);
                chk("count4_17", {28'b0, rd_count4}, 32'd1);
            end
        end
        step(1'b1, 1'b0, 0, 1'b0);
        chk("bp_done_valid", {31'b0, m_valid},  32'd0);
        chk("bp_count",      {16'b0, rd_count}, 32'd22);

        // Reset while a word is buffered and another is in flight.
        next_val = 8'hB0;
        step(1'b0, 1'b0, 6, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        chk("mr_rd_en_pre", {31'b0, fifo_rd_en}, 32'd1);
        step(1'b0, 1'b1, 0, 1'b0);
        flush = 1'b1;
        sb.delete();
        chk("mr_occ_pre",  {30'b0, dut.r_occ}, 32'd1);
        chk("mr_infl_pre", {31'b0, dut.r_infl}, 32'd1);
        chk("mr_rd_en_rst", {31'b0, fifo_rd_en}, 32'd0);
        step(1'b1, 1'b0, 0, 1'b0);
        flush = 1'b0;
        chk("mr_valid",  {31'b0, m_valid},   32'd0);
        chk("mr_data",   {24'b0, m_data},    32'd0);
        chk("mr_count",  {16'b0, rd_count},  32'd0);
        chk("mr_count4", {28'b0, rd_count4}, 32'd0);
        chk("mr_rd_en",  {31'b0, fifo_rd_en}, 32'd0);

        // Refill after reset.
        next_val = 8'hC0;
        step(1'b1, 1'b0, 4, 1'b0);
        chk("rf_rd_en",   {31'b0, fifo_rd_en}, 32'd1);
        chk("rf_valid0",  {31'b0, m_valid},    32'd0);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("rf_valid1",  {31'b0, m_valid},    32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 0, 1'b0);
            chk("rf_valid", {31'b0, m_valid}, 32'd1);
            chk("rf_data",  {24'b0, m_data},  32'(8'hC0 + i));
        end
        step(1'b1, 1'b0, 0, 1'b0);
        chk("rf_done_valid", {31'b0, m_valid},  32'd0);
        chk("rf_count",      {16'b0, rd_count}, 32'd4);

        // Random ready and FIFO-empty gaps, 1000 words.
        sent = 0;
        for (int c = 0; c < 20000; c++) begin
            if (sent == 1000 && sb.size() == 0) break;
            np = (sent < 1000 && $urandom_range(0, 3) != 0) ? 1 : 0;
            next_val = 8'($urandom);
            step(1'($urandom_range(0, 1)), 1'b0, np, ($urandom_range(0, 3) == 0));
            sent += np;
        end
        chk("rand_drained", {31'b0, (sent == 1000) && (sb.size() == 0)}, 32'd1);
        step(1'b0, 1'b0, 0, 1'b0);
        chk("rand_count",  {16'b0, rd_count},  32'd1004);
        chk("rand_count4", {28'b0, rd_count4}, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
